// File: rtl/bit_sampler_deser_if.sv
// bit_sampler_deser_if: byte delivery channel of the bit sampler/deserializer.
//   data_out   [7:0] : deserialized byte, first received bit in bit 7
//   data_valid       : data_out holds a byte not yet taken by the consumer
//   data_ready       : consumer accepts data_out when high with data_valid
//   overrun          : one-cycle pulse when an untaken byte was overwritten
// Modports: master = deserializer (byte producer), slave = consumer.
interface bit_sampler_deser_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       overrun;

  modport master (
    output data_out,
    output data_valid,
    output overrun,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  overrun,
    output data_ready
  );
endinterface

// File: rtl/bit_sampler_deser.sv
// bit_sampler_deser: samples the asynchronous serial line at mid-bit using a
// phase counter re-aligned on every data edge, hunts for SYNC_WORD and then
// deserializes the stream into bytes over a valid/ready channel.
//
// Ports:
//   clk_200M       : sole clock, all logic on posedge
//   rst            : synchronous active-high reset
//   signal         : asynchronous serial data
//   clk_freq [15:0]: bit period in clk_200M cycles (recovery stage output)
//   sync_pulse     : one-cycle pulse when SYNC_WORD is matched
//   locked         : high while deserializing data bytes
//   bus            : byte channel (bit_sampler_deser_if.master)
//
// Build option: BIT_SAMPLER_MAJORITY_EN -- 2-of-3 majority sampling at
// half-1/half/half+1 (one extra cycle of sample latency). Undefined: single
// sample at phase == half.
//
// state  | meaning
// IDLE   | bit period out of range, waiting for a valid clk_freq
// HUNT   | shift register cleared, waiting for the first data edge
// SEARCH | shifting samples, looking for SYNC_WORD
// DATA   | locked, assembling bytes of 8 samples
module bit_sampler_deser #(
  parameter logic [7:0]  SYNC_WORD  = 8'hA5,
  parameter logic [15:0] MIN_PERIOD = 16'd4,
  parameter logic [15:0] MAX_PERIOD = 16'd800,
  parameter logic [3:0]  MAX_RUN    = 4'd8
) (
  input  logic        clk_200M,
  input  logic        rst,
  input  logic        signal,
  input  logic [15:0] clk_freq,
  output logic        sync_pulse,
  output logic        locked,
  bit_sampler_deser_if.master bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HUNT   = 2'd1;
  localparam logic [1:0] ST_SEARCH = 2'd2;
  localparam logic [1:0] ST_DATA   = 2'd3;

  logic        sig_m;
  logic        sig_s;
  logic        sig_d;
  logic        edge_det;
  logic        pv;
  logic [15:0] half;
  logic [15:0] phase;
  logic        phase_wrap;
  logic        hit;
  logic        hit_bit;
  logic        samp_vld;
  logic        samp_bit;
  logic [3:0]  run_cnt;
  logic [3:0]  run_nxt;
  logic        run_loss;
  logic [7:0]  shreg;
  logic [7:0]  shifted;
  logic [2:0]  bit_cnt;
  logic [1:0]  state;
  logic [7:0]  data_out_q;
  logic        data_valid_q;
  logic        overrun_q;

  always_ff @(posedge clk_200M) begin
    if (rst) begin
      sig_m <= 1'b0;
      sig_s <= 1'b0;
      sig_d <= 1'b0;
    end else begin
      sig_m <= signal;
      sig_s <= sig_m;
      sig_d <= sig_s;
    end
  end

  assign pv   = (clk_freq >= MIN_PERIOD) && (clk_freq <= MAX_PERIOD);
  assign half = clk_freq >> 1;

  // clk_freq-1 only matters while pv holds; an invalid period parks phase at 0.
  assign phase_wrap = !pv || (phase >= clk_freq - 16'd1);

`ifdef BIT_SAMPLER_MAJORITY_EN
  logic s_early;
  logic s_mid;
  logic in_win;

  // A transition inside the three-sample window is treated as a glitch so it
  // cannot throw away the partially collected vote.
  assign in_win   = pv && (phase >= half - 16'd1) && (phase <= half + 16'd1);
  assign edge_det = (sig_s != sig_d) && !in_win;
  assign hit      = (phase == half + 16'd1);
  assign hit_bit  = (s_early & s_mid) | (s_early & sig_s) | (s_mid & sig_s);

  always_ff @(posedge clk_200M) begin
    if (rst) begin
      s_early <= 1'b0;
      s_mid   <= 1'b0;
    end else begin
      if (phase == half - 16'd1) s_early <= sig_s;
      if (phase == half)         s_mid   <= sig_s;
    end
  end
`else
  assign edge_det = (sig_s != sig_d);
  assign hit      = (phase == half);
  assign hit_bit  = sig_s;
`endif

  always_ff @(posedge clk_200M) begin
    if (rst) begin
      phase    <= 16'd0;
      samp_vld <= 1'b0;
      samp_bit <= 1'b0;
      run_cnt  <= 4'd0;
    end else begin
      if (edge_det || phase_wrap) phase <= 16'd0;
      else                        phase <= phase + 16'd1;
      samp_vld <= hit;
      samp_bit <= hit_bit;
      run_cnt  <= run_nxt;
    end
  end

  // Samples since the last edge, saturating; an edge always restarts the run.
  always_comb begin
    run_nxt = run_cnt;
    if (edge_det)                           run_nxt = 4'd0;
    else if (samp_vld && run_cnt != 4'hF)   run_nxt = run_cnt + 4'd1;
  end

  assign run_loss = samp_vld && !edge_det && (run_nxt >= MAX_RUN);
  assign shifted  = {shreg[6:0], samp_bit};

  always_ff @(posedge clk_200M) begin
    if (rst) begin
      state        <= ST_IDLE;
      shreg        <= 8'd0;
      bit_cnt      <= 3'd0;
      data_out_q   <= 8'd0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      sync_pulse   <= 1'b0;
    end else begin
      sync_pulse <= 1'b0;
      overrun_q  <= 1'b0;
      if (data_valid_q && bus.data_ready) data_valid_q <= 1'b0;

      if (!pv) begin
        state   <= ST_IDLE;
        shreg   <= 8'd0;
        bit_cnt <= 3'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_HUNT;
          end
          ST_HUNT: begin
            shreg   <= 8'd0;
            bit_cnt <= 3'd0;
            if (edge_det) state <= ST_SEARCH;
          end
          ST_SEARCH, ST_DATA: begin
            if (run_loss) begin
              state   <= ST_HUNT;
              shreg   <= 8'd0;
              bit_cnt <= 3'd0;
            end else if (samp_vld) begin
              shreg <= shifted;
              if (state == ST_SEARCH) begin
                if (shifted == SYNC_WORD) begin
                  sync_pulse <= 1'b1;
                  bit_cnt    <= 3'd0;
                  state      <= ST_DATA;
                end
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  // A load in the same cycle as a transfer wins over the clear.
                  data_out_q   <= shifted;
                  data_valid_q <= 1'b1;
                  overrun_q    <= data_valid_q && !bus.data_ready;
                end
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign locked         = (state == ST_DATA);
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: doc/bit_sampler_deser.md
# bit_sampler_deser

Downstream stage of the bit clock recovery block. Takes the raw serial `signal` and the recovered bit interval `clk_freq` (in `clk_200M` cycles) and re-aligns a sampling phase counter on every data edge. It samples each bit at mid-period, hunts for a sync byte, then deserializes the stream into bytes delivered over a valid/ready interface.

## Interface
- `SYNC_WORD`, 8'hA5: frame sync byte, matched MSB-first.
- `MIN_PERIOD`, 4: smallest accepted `clk_freq`.
- `MAX_PERIOD`, 800: largest accepted `clk_freq`. The recovery block's reset value 801 is therefore invalid.
- `MAX_RUN`, 8: consecutive samples without an edge before lock is dropped.
- `clk_200M` input 1: sole clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `signal` input 1: asynchronous serial data.
- `clk_freq` input 16: bit period in `clk_200M` cycles, from the recovery stage.
- `data_ready` input 1: consumer accepts `data_out` when high together with `data_valid`.
- `data_out` output 8: deserialized byte, MSB first received.
- `data_valid` output 1: `data_out` holds an untransferred byte.
- `overrun` output 1: one-cycle pulse when an untransferred byte is overwritten.
- `sync_pulse` output 1: one-cycle pulse when `SYNC_WORD` is matched.
- `locked` output 1: high while in state DATA.

## Operation
- **Input conditioning:** `signal` passes through a 2-flop synchronizer giving `sig_s`, plus a delay flop `sig_d`. An edge is `sig_s != sig_d`.
- **Phase counter** (`phase`, 16 bits):
  - On an edge, `phase <= 0`.
  - Otherwise, if `phase >= clk_freq-1`, `phase <= 0` (free-running wrap; `>=` tolerates `clk_freq` shrinking mid-bit).
  - Otherwise `phase <= phase+1`.
- **Sample point:** `half = clk_freq>>1`. A sample is taken when `phase == half`; see Configuration for the majority variant.
- **Period validity:** `pv = (clk_freq >= MIN_PERIOD) && (clk_freq <= MAX_PERIOD)`.
- **Run counter:** 4 bits. Cleared on an edge, incremented per sample, saturating. Reaching `MAX_RUN` flags loss of transitions.
- **Shift register:** `shreg` shifts left on each sample, with the new bit entering at bit 0.
- **States:**
  - IDLE: wait for `pv`, then go to HUNT.
  - HUNT: `shreg` is cleared; first edge goes to SEARCH.
  - SEARCH: shift each sample. When the post-shift `shreg == SYNC_WORD`, pulse `sync_pulse`, clear `bit_cnt`, and go to DATA.
  - DATA: shift each sample and increment 3-bit `bit_cnt`. On the 8th sample (`bit_cnt` 7 wraps to 0), load the post-shift `shreg` into `data_out` and set `data_valid`.
- **Transitions from any non-IDLE state:**
  - `!pv` goes to IDLE.
  - Run counter reaching `MAX_RUN` goes to HUNT.
  - A partial byte is discarded. An already-held `data_out`/`data_valid` is kept.
- **Handshake:**
  - A transfer occurs when `data_valid && data_ready`; `data_valid` clears the next cycle.
  - A byte completing with `data_valid && !data_ready` overwrites `data_out`, keeps `data_valid` high, and pulses `overrun`.
  - A byte completing in the same cycle as a transfer loads the new byte with `data_valid` staying 1 and no `overrun`.
- **Arithmetic:** all counters are unsigned. `clk_freq-1` is evaluated only when `pv` holds, so no underflow.

## Timing
- **Reset:** state IDLE; `phase`, `shreg`, `bit_cnt`, and the run counter are 0. `data_out`=0, `data_valid`=0, `overrun`=0, `sync_pulse`=0, `locked`=0. Synchronizer flops are 0.
- **Edge latency:** a `signal` transition produces an edge 2 cycles later; `phase` reads 0 on the cycle after that.
- **Sample latency:** the sample is registered on the cycle following `phase == half` (single-sample build).
- **Byte output:** `data_valid` rises 1 cycle after the 8th sample is registered. `sync_pulse` and `locked` rise 1 cycle after the matching sample.
- **Throughput:** one byte per 8·`clk_freq` cycles. The consumer must accept within that window to avoid `overrun`.
- **Reset mid-operation:** `rst` overrides everything; all outputs are 0 on the next cycle.

## Configuration
- Macro: `BIT_SAMPLER_MAJORITY_EN`.
- **Defined:** samples at `phase == half-1`, `half`, `half+1`. The bit is the 2-of-3 majority, committed at `half+1`, which adds one cycle of sample latency. `MIN_PERIOD` must be ≥4 so that `half-1 ≥ 1`.
- **Undefined:** single sample at `phase == half`; the extra sample flops are absent.

## Test plan
- **Sync and data:** `clk_freq`=20, NRZ bits of 0xA5 then 0x3C, `data_ready`=1 → `sync_pulse` once, `locked`=1, one `data_valid` pulse with `data_out`=0x3C.
- **Overrun:** `clk_freq`=20, sync then 0x11, 0x22 with `data_ready`=0 → `overrun` pulses once at the second byte; `data_out`=0x22 and `data_valid`=1 until `data_ready` is raised.
- **Loss of transitions:** `clk_freq`=20, lock, then hold `signal` high for 9 bit periods → `locked` falls after the 8th sample; state is HUNT and no byte is emitted.
- **Invalid period:** `clk_freq`=801 with valid traffic → stays IDLE, all outputs 0. Then step to 40 → next sync at 40-cycle bits locks.
- **Majority (macro on):** `clk_freq`=20, sync then 0x5A with a 1-cycle glitch injected at `phase == half` on every bit → `data_out`=0x5A. The same stimulus with the macro off → corrupted byte ≠0x5A.
- **Reset mid-byte:** assert `rst` 1 cycle after the 4th DATA bit → next cycle all outputs are 0. Resync then yields a correct byte.
